exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Sequences the Execute ALU between decode and register writeback; one instruction in flight.
//  Accepts a decoded op via valid/ready and gates the ALU with alu_can_execute.
//  Waits a fixed latency for multiply ops, then captures alu_result/alu_result_special.
//  Emits 1-2 register writes (RDX:RAX for MUL) through a single-port valid/ready writeback.
//  Replaces $finish on RET/RETF/IRET (C3/CB/CF) with a sticky halted flag.
// PARAMETERS
//  MUL_LATENCY  3   cycles alu_can_execute is held for multiply ops before capture (legal 1..15)
//  DATA_WIDTH   64  width of ALU results and writeback data
// PORTS
//  clk                     in   1   clock; all state updates on posedge
//  reset                   in   1   asynchronous, active-high reset
//  dec_valid               in   1   decode presents an op
//  dec_ready               out  1   sequencer can accept an op
//  dec_opcode              in   8   opcode byte
//  dec_opcode_length       in   2   opcode length in bytes (1 or 2)
//  dec_has_ext             in   1   ModRM reg field is an extended opcode
//  dec_ext_opcode          in   3   extended opcode value
//  dec_writes_dest         in   1   op writes dec_dest_reg (0 for CMP and similar)
//  dec_dest_reg            in   4   primary destination register
//  dec_dest_reg_special    in   4   secondary destination register (RDX for MUL)
//  dec_dest_special_valid  in   1   secondary write required
//  alu_can_execute         out  1   enables the ALU
//  alu_result              in   DW  ALU primary result
//  alu_result_special      in   DW  ALU upper/secondary result
//  wb_valid                out  1   write request to the register file
//  wb_ready                in   1   register file accepts the write
//  wb_reg                  out  4   write register index
//  wb_data                 out  DW  write data
//  halted                  out  1   sticky; halt op has retired
//  retired_count           out  32  retired-op counter, wraps
// BEHAVIOUR
//  Reset: state=IDLE; dec_ready=0 while reset is asserted, 1 from the first cycle after release.
//   All other outputs and internal registers reset to 0. Reset mid-op drops the op and any pending write.
//  States: IDLE, EXEC, MUL_WAIT, WB_PRI, WB_SPC, HALT.
//  dec_ready = (state==IDLE), decoded from the state register only; no combinational path from dec_valid.
//  IDLE: on dec_valid, capture dest/special/writes_dest/dest_special_valid and classify the op:
//   halt: len1 and opcode C3, CB or CF -> HALT.
//   mul: (len1, F7, ext 100 or 101) | (len1, 6B or 69) | (len2, AF) -> MUL_WAIT, cnt=MUL_LATENCY-1.
//   else -> EXEC.
//  Decode holds its ALU-facing operand/opcode fields stable until dec_ready is high again.
//  alu_can_execute = (state==EXEC) | (state==MUL_WAIT); it is 0 in every other state.
//  EXEC: one cycle. Capture alu_result into res_q.
//   -> WB_PRI if writes_dest, else -> IDLE (op retires).
//  MUL_WAIT: if cnt==0, capture res_q=alu_result and spc_q=alu_result_special, then -> WB_PRI;
//   else cnt-=1. Total MUL_LATENCY cycles, so MUL_LATENCY=1 behaves like EXEC.
//  WB_PRI: wb_valid=1, wb_reg=dest, wb_data=res_q.
//   On wb_ready: -> WB_SPC if dest_special_valid, else -> IDLE (op retires).
//  WB_SPC: wb_valid=1, wb_reg=dest_special, wb_data=spc_q. On wb_ready -> IDLE (op retires).
//  While wb_valid=1 and wb_ready=0: wb_reg and wb_data hold stable; no timeout.
//  wb_valid=0 outside WB_PRI/WB_SPC; wb_reg and wb_data are 0 there.
//  HALT: terminal until reset. halted=1 from the cycle after acceptance; dec_ready=0; dec_valid ignored.
//  Retirement: retired_count += 1 on entering IDLE from EXEC/WB_PRI/WB_SPC and on entering HALT.
//   32-bit counter, wraps 0xFFFFFFFF -> 0.
//  Throughput with wb_ready=1 (accept to dec_ready re-high):
//   non-mul write: 3 cycles; mul with 2 writes: MUL_LATENCY+3 cycles.
//  dec_special_valid is only honoured for ops that also have writes_dest=1.
// TESTING
//  ADD 01, dest=3, writes=1, alu_result=5, wb_ready=1 -> can_execute 1 cyc;
//   wb_valid/reg=3/data=5 next cyc; dec_ready high 3 cyc after accept; retired_count=1.
//  MUL F7 /4, LAT=3, dest=0, spc=2 valid, lo=0x10 hi=0x2 -> can_execute 3 cyc;
//   then wb (0,0x10) and (2,0x2) on consecutive cycles.
//  WB stall: wb_ready=0 for 5 cycles in WB_PRI -> wb_valid/reg/data stable, dec_ready=0;
//   wb_ready=1 -> completes.
//  CMP 39 with writes=0 -> no wb_valid ever; dec_ready high after EXEC; retired_count increments.
//  C3 accepted -> halted=1, dec_ready=0; dec_valid pulses ignored for 10 cycles; reset clears halted.
//  Reset asserted in 2nd MUL_WAIT cycle -> all outputs 0 asynchronously; no wb after release;
//   force retired_count=0xFFFFFFFF, retire one op -> 0.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: decode, ALU-gating and writeback signals of the execute sequencer
//   master: sequencer side (drives dec_ready, alu_can_execute, wb_valid/wb_reg/wb_data)
//   slave : decode/ALU/register-file side (drives dec_*, alu_result*, wb_ready)
interface exec_sequencer_if #(parameter int DATA_WIDTH = 64);
  logic                  dec_valid;
  logic                  dec_ready;
  logic [7:0]            dec_opcode;
  logic [1:0]            dec_opcode_length;
  logic                  dec_has_ext;
  logic [2:0]            dec_ext_opcode;
  logic                  dec_writes_dest;
  logic [3:0]            dec_dest_reg;
  logic [3:0]            dec_dest_reg_special;
  logic                  dec_dest_special_valid;
  logic                  alu_can_execute;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] alu_result_special;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [3:0]            wb_reg;
  logic [DATA_WIDTH-1:0] wb_data;
  modport master (
    input  dec_valid, dec_opcode, dec_opcode_length, dec_has_ext, dec_ext_opcode,
           dec_writes_dest, dec_dest_reg, dec_dest_reg_special, dec_dest_special_valid,
           alu_result, alu_result_special, wb_ready,
    output dec_ready, alu_can_execute, wb_valid, wb_reg, wb_data
  );
  modport slave (
    output dec_valid, dec_opcode, dec_opcode_length, dec_has_ext, dec_ext_opcode,
           dec_writes_dest, dec_dest_reg, dec_dest_reg_special, dec_dest_special_valid,
           alu_result, alu_result_special, wb_ready,
    input  dec_ready, alu_can_execute, wb_valid, wb_reg, wb_data
  );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: one-op-in-flight sequencer between decode, the execute ALU and register writeback
//   clk, reset     : clock, asynchronous active-high reset
//   bus (master)   : decode valid/ready, ALU enable/results, single-port writeback valid/ready
//   halted         : sticky, set once a RET/RETF/IRET op has been accepted
//   retired_count  : wrapping count of retired ops
module exec_sequencer #(
  parameter int MUL_LATENCY = 3,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                clk,
  input  logic                reset,
  exec_sequencer_if.master    bus,
  output logic                halted,
  output logic [31:0]         retired_count
);
  typedef enum logic [2:0] {IDLE, EXEC, MUL_WAIT, WB_PRI, WB_SPC, HALT} state_t;
  localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d, dest_q, dest_d, spc_reg_q, spc_reg_d, wb_reg_q, wb_reg_d;
  logic                  wr_q, wr_d, spv_q, spv_d, dec_ready_q, dec_ready_d;
  logic                  alu_en_q, alu_en_d, wb_valid_q, wb_valid_d, halted_q, halted_d;
  logic [DATA_WIDTH-1:0] spc_q, spc_d, wb_data_q, wb_data_d;
  logic [31:0]           retired_count_q, retired_count_d;
  logic                  is_halt, is_mul, accept, retire;
  always_comb begin
    is_halt = bus.dec_opcode_length == 2'd1 &&
              (bus.dec_opcode == 8'hC3 || bus.dec_opcode == 8'hCB || bus.dec_opcode == 8'hCF);
    is_mul  = (bus.dec_opcode_length == 2'd1 &&
               ((bus.dec_opcode == 8'hF7 && bus.dec_has_ext &&
                 (bus.dec_ext_opcode == 3'd4 || bus.dec_ext_opcode == 3'd5)) ||
                bus.dec_opcode == 8'h6B || bus.dec_opcode == 8'h69)) ||
              (bus.dec_opcode_length == 2'd2 && bus.dec_opcode == 8'hAF);
    // dec_ready_q is only ever high in IDLE, so it doubles as the IDLE qualifier
    accept  = dec_ready_q & bus.dec_valid;
    state_d = accept                ? (is_halt ? HALT : is_mul ? MUL_WAIT : EXEC) :
              state_q == EXEC       ? (wr_q ? WB_PRI : IDLE) :
              state_q == MUL_WAIT   ? (cnt_q == 4'd0 ? WB_PRI : MUL_WAIT) :
              state_q == WB_PRI     ? (bus.wb_ready ? (spv_q ? WB_SPC : IDLE) : WB_PRI) :
              state_q == WB_SPC     ? (bus.wb_ready ? IDLE : WB_SPC) : state_q;
    cnt_d     = accept ? CNT_INIT : (state_q == MUL_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    dest_d    = accept ? bus.dec_dest_reg : dest_q;
    spc_reg_d = accept ? bus.dec_dest_reg_special : spc_reg_q;
    wr_d      = accept ? bus.dec_writes_dest : wr_q;
    // a secondary write only makes sense alongside a primary one
    spv_d     = accept ? bus.dec_dest_special_valid & bus.dec_writes_dest : spv_q;
    spc_d     = (state_q == MUL_WAIT && cnt_q == 4'd0) ? bus.alu_result_special : spc_q;
    retire    = (state_d == IDLE && (state_q == EXEC || state_q == WB_PRI || state_q == WB_SPC)) ||
                (state_d == HALT && state_q == IDLE);
    retired_count_d = retired_count_q + {31'd0, retire};
    // outputs are registered from the next state so they line up with the state register
    dec_ready_d = state_d == IDLE;
    alu_en_d    = state_d == EXEC || state_d == MUL_WAIT;
    halted_d    = state_d == HALT;
    wb_valid_d  = state_d == WB_PRI || state_d == WB_SPC;
    wb_reg_d    = state_d == WB_PRI ? dest_d : state_d == WB_SPC ? spc_reg_d : 4'd0;
    // wb_data_q itself holds the primary result while WB_PRI stalls
    wb_data_d   = state_d == WB_PRI ? (state_q == WB_PRI ? wb_data_q : bus.alu_result) :
                  state_d == WB_SPC ? spc_d : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      dest_q          <= '0;
      spc_reg_q       <= '0;
      wr_q            <= 1'b0;
      spv_q           <= 1'b0;
      spc_q           <= '0;
      retired_count_q <= '0;
      dec_ready_q     <= 1'b0;
      alu_en_q        <= 1'b0;
      halted_q        <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_reg_q        <= '0;
      wb_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      dest_q          <= dest_d;
      spc_reg_q       <= spc_reg_d;
      wr_q            <= wr_d;
      spv_q           <= spv_d;
      spc_q           <= spc_d;
      retired_count_q <= retired_count_d;
      dec_ready_q     <= dec_ready_d;
      alu_en_q        <= alu_en_d;
      halted_q        <= halted_d;
      wb_valid_q      <= wb_valid_d;
      wb_reg_q        <= wb_reg_d;
      wb_data_q       <= wb_data_d;
    end
  end
  assign bus.dec_ready       = dec_ready_q;
  assign bus.alu_can_execute = alu_en_q;
  assign bus.wb_valid        = wb_valid_q;
  assign bus.wb_reg          = wb_reg_q;
  assign bus.wb_data         = wb_data_q;
  assign halted              = halted_q;
  assign retired_count       = retired_count_q;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: scoreboard bench for exec_sequencer with directed ops
module tb_exec_sequencer;
  typedef struct packed {logic [3:0] r; logic [63:0] d;} exp_t;
  logic clk = 1'b0, reset = 1'b1, halted;
  logic [31:0] retired_count;
  int checks = 0, errors = 0;
  exp_t sb[$];
  exec_sequencer_if #(.DATA_WIDTH(64)) ifc ();
  exec_sequencer #(.MUL_LATENCY(3), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .bus(ifc), .halted(halted), .retired_count(retired_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [7:0] op, input logic [1:0] len, input logic [2:0] ext,
                       input logic wr, input logic [3:0] d, input logic [3:0] s, input logic sv);
    int n = 0;
    while (!ifc.dec_ready && n < 50) begin
      tick();
      n++;
    end
    chk("issue_ready", ifc.dec_ready, 1'b1);
    ifc.dec_opcode = op; ifc.dec_opcode_length = len; ifc.dec_has_ext = 1'b1;
    ifc.dec_ext_opcode = ext; ifc.dec_writes_dest = wr; ifc.dec_dest_reg = d;
    ifc.dec_dest_reg_special = s; ifc.dec_dest_special_valid = sv;
    ifc.dec_valid = 1'b1;
    tick();
    ifc.dec_valid = 1'b0;
  endtask
  // monitor: every presented write is checked against the scoreboard head, popped on handshake
  always @(negedge clk) begin
    if (!reset && ifc.wb_valid) begin
      if (sb.size() == 0) chk("wb_unexpected", ifc.wb_valid, 1'b0);
      else begin
        chk("wb_reg", {60'd0, ifc.wb_reg}, {60'd0, sb[0].r});
        chk("wb_data", ifc.wb_data, sb[0].d);
        if (ifc.wb_ready) void'(sb.pop_front());
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    ifc.dec_valid = 0; ifc.dec_opcode = 0; ifc.dec_opcode_length = 0; ifc.dec_has_ext = 0;
    ifc.dec_ext_opcode = 0; ifc.dec_writes_dest = 0; ifc.dec_dest_reg = 0;
    ifc.dec_dest_reg_special = 0; ifc.dec_dest_special_valid = 0;
    ifc.alu_result = 0; ifc.alu_result_special = 0; ifc.wb_ready = 1'b1;
    #12;
    chk("rst_dec_ready", ifc.dec_ready, 1'b0);
    chk("rst_wb_valid", ifc.wb_valid, 1'b0);
    chk("rst_alu_en", ifc.alu_can_execute, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_count", retired_count, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    tick();
    chk("post_rst_ready", ifc.dec_ready, 1'b1);
    // ADD
    ifc.alu_result = 64'd5;
    sb.push_back('{r: 4'd3, d: 64'd5});
    issue(8'h01, 2'd1, 3'd0, 1'b1, 4'd3, 4'd0, 1'b0);
    chk("add_alu_en", ifc.alu_can_execute, 1'b1);
    chk("add_busy", ifc.dec_ready, 1'b0);
    tick();
    chk("add_alu_off", ifc.alu_can_execute, 1'b0);
    chk("add_wb_valid", ifc.wb_valid, 1'b1);
    tick();
    chk("add_ready", ifc.dec_ready, 1'b1);
    chk("add_count", retired_count, 32'd1);
    // MUL F7 /4 with RDX:RAX
    ifc.alu_result = 64'h10; ifc.alu_result_special = 64'h2;
    sb.push_back('{r: 4'd0, d: 64'h10});
    sb.push_back('{r: 4'd2, d: 64'h2});
    issue(8'hF7, 2'd1, 3'd4, 1'b1, 4'd0, 4'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("mul_alu_en", ifc.alu_can_execute, 1'b1);
      chk("mul_no_wb", ifc.wb_valid, 1'b0);
      tick();
    end
    chk("mul_alu_off", ifc.alu_can_execute, 1'b0);
    chk("mul_wb_pri", {60'd0, ifc.wb_reg}, 64'd0);
    tick();
    chk("mul_wb_spc", {60'd0, ifc.wb_reg}, 64'd2);
    tick();
    chk("mul_ready", ifc.dec_ready, 1'b1);
    chk("mul_count", retired_count, 32'd2);
    // writeback stall
    ifc.wb_ready = 1'b0;
    ifc.alu_result = 64'hABCD;
    sb.push_back('{r: 4'd7, d: 64'hABCD});
    issue(8'h01, 2'd1, 3'd0, 1'b1, 4'd7, 4'd0, 1'b0);
    tick();
    ifc.alu_result = 64'hDEAD;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", ifc.wb_valid, 1'b1);
      chk("stall_busy", ifc.dec_ready, 1'b0);
      tick();
    end
    ifc.wb_ready = 1'b1;
    tick();
    chk("stall_ready", ifc.dec_ready, 1'b1);
    chk("stall_count", retired_count, 32'd3);
    // NEG (F7 /3) is not a multiply
    ifc.alu_result = 64'hFFFF_FFFF_FFFF_FFFB;
    sb.push_back('{r: 4'd9, d: 64'hFFFF_FFFF_FFFF_FFFB});
    issue(8'hF7, 2'd1, 3'd3, 1'b1, 4'd9, 4'd0, 1'b0);
    tick();
    chk("neg_wb_valid", ifc.wb_valid, 1'b1);
    tick();
    chk("neg_count", retired_count, 32'd4);
    // CMP: no write, special valid ignored
    issue(8'h39, 2'd1, 3'd0, 1'b0, 4'd4, 4'd5, 1'b1);
    chk("cmp_alu_en", ifc.alu_can_execute, 1'b1);
    tick();
    chk("cmp_no_wb", ifc.wb_valid, 1'b0);
    chk("cmp_ready", ifc.dec_ready, 1'b1);
    chk("cmp_count", retired_count, 32'd5);
    // IMUL 0F AF
    ifc.alu_result = 64'h1234_5678_9ABC_DEF0;
    sb.push_back('{r: 4'd5, d: 64'h1234_5678_9ABC_DEF0});
    issue(8'hAF, 2'd2, 3'd0, 1'b1, 4'd5, 4'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("imul_alu_en", ifc.alu_can_execute, 1'b1);
      tick();
    end
    chk("imul_wb_valid", ifc.wb_valid, 1'b1);
    tick();
    chk("imul_ready", ifc.dec_ready, 1'b1);
    chk("imul_count", retired_count, 32'd6);
    // halt
    issue(8'hC3, 2'd1, 3'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("halt_flag", halted, 1'b1);
    chk("halt_count", retired_count, 32'd7);
    for (int i = 0; i < 10; i++) begin
      ifc.dec_valid = i[0];
      tick();
      chk("halt_busy", ifc.dec_ready, 1'b0);
      chk("halt_alu_off", ifc.alu_can_execute, 1'b0);
      chk("halt_hold", halted, 1'b1);
    end
    ifc.dec_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("halt_rst_clear", halted, 1'b0);
    chk("halt_rst_count", retired_count, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    tick();
    chk("halt_rst_ready", ifc.dec_ready, 1'b1);
    // reset in the second MUL_WAIT cycle drops the op
    issue(8'h69, 2'd1, 3'd0, 1'b1, 4'd1, 4'd0, 1'b0);
    tick();
    chk("mid_alu_en", ifc.alu_can_execute, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_alu_off", ifc.alu_can_execute, 1'b0);
    chk("mid_ready", ifc.dec_ready, 1'b0);
    chk("mid_wb", ifc.wb_valid, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (8) tick();
    chk("mid_after_ready", ifc.dec_ready, 1'b1);
    chk("mid_after_count", retired_count, 32'd0);
    // counter wrap
    force dut.retired_count_q = 32'hFFFF_FFFF;
    tick();
    release dut.retired_count_q;
    chk("wrap_pre", retired_count, 32'hFFFF_FFFF);
    ifc.alu_result = 64'h77;
    sb.push_back('{r: 4'd1, d: 64'h77});
    issue(8'h01, 2'd1, 3'd0, 1'b1, 4'd1, 4'd0, 1'b0);
    tick();
    tick();
    chk("wrap_count", retired_count, 32'd0);
    repeat (3) tick();
    chk("sb_empty", sb.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
